// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
// FSM state encoding, memory read/write codes, port selectors.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_RELEASE
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_req_grant.sv
// Two-way alternating-priority grant between the I and D ports.
// Ports: clk_i/rst_i, i_req_i/d_req_i requests, take_i grant accepted,
//        valid_o some request present, port_o selected port.
module mem_req_grant
  import mem_port_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic take_i,
  output logic valid_o,
  output logic port_o
);

  logic ptr_q;
  logic ptr_d;
  logic both;

  assign both    = i_req_i && d_req_i;
  assign valid_o = i_req_i || d_req_i;

  always_comb begin
    port_o = ptr_q;
    unique case (1'b1)
      both:                  port_o = ptr_q;
      (d_req_i && !i_req_i): port_o = PORT_D;
      (i_req_i && !d_req_i): port_o = PORT_I;
      default:               port_o = ptr_q;
    endcase
  end

  // Pointer only moves when a contended grant is taken.
  always_comb begin
    ptr_d = ptr_q;
    if (take_i && both) begin
      ptr_d = (port_o == PORT_D) ? PORT_I : PORT_D;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= PORT_D;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the main memory between fetch (I) and load/store (D) ports.
// Ports: I/D Req/Ack requester side, Mem* memory Enable/RW/MOC side, Err timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic [DATA_W-1:0] IData,
  output logic              IAck,
  input  logic              DReq,
  input  logic              DRW,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic [DATA_W-1:0] DRData,
  output logic              DAck,
  output logic              Err,
  output logic              MemEnable,
  output logic              MemReadWrite,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataIn,
  input  logic [DATA_W-1:0] MemDataOut,
  input  logic              MemMOC
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e state_q;
  state_e state_d;

  logic              gnt_valid;
  logic              gnt_port;
  logic              take;
  logic              last_wait;
  logic              port_q;
  logic              rw_q;
  logic              tout_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] idata_q;
  logic [DATA_W-1:0] drdata_q;
  logic [CNT_W-1:0]  cnt_q;

  // A stale MOC from the previous access blocks new grants.
  assign take = (state_q == S_IDLE) && !MemMOC && gnt_valid;

  assign last_wait = (cnt_q == CNT_W'(TIMEOUT - 1));

  mem_req_grant u_grant (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .i_req_i (IReq),
    .d_req_i (DReq),
    .take_i  (take),
    .valid_o (gnt_valid),
    .port_o  (gnt_port)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = S_SETUP;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_WAIT;
      S_WAIT: begin
        if (MemMOC || last_wait) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      port_q   <= PORT_D;
      rw_q     <= RW_WRITE;
      addr_q   <= '0;
      wdata_q  <= '0;
      idata_q  <= '0;
      drdata_q <= '0;
      cnt_q    <= '0;
      tout_q   <= 1'b0;
    end else begin
      if (take) begin
        port_q <= gnt_port;
        if (gnt_port == PORT_D) begin
          addr_q  <= DAddr;
          rw_q    <= DRW;
          wdata_q <= DWData;
        end else begin
          addr_q  <= IAddr;
          rw_q    <= RW_READ;
          wdata_q <= '0;
        end
      end
      if (state_q == S_STROBE) begin
        cnt_q  <= '0;
        tout_q <= 1'b0;
      end
      if (state_q == S_WAIT) begin
        if (MemMOC) begin
          if (rw_q == RW_READ) begin
            if (port_q == PORT_I) begin
              idata_q <= MemDataOut;
            end else begin
              drdata_q <= MemDataOut;
            end
          end
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_wait) begin
            tout_q <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    MemEnable = 1'b0;
    IAck      = 1'b0;
    DAck      = 1'b0;
    Err       = 1'b0;
    unique case (state_q)
      S_STROBE, S_WAIT: MemEnable = 1'b1;
      S_RELEASE: begin
        IAck = (port_q == PORT_I);
        DAck = (port_q == PORT_D);
        Err  = tout_q;
      end
      default: ;
    endcase
  end

  assign MemAddress   = addr_q;
  assign MemReadWrite = rw_q;
  assign MemDataIn    = wdata_q;
  assign IData        = idata_q;
  assign DRData       = drdata_q;

endmodule
